// File: rtl/ivector_pkg.sv
// Shared widths, FSM state type and the packed {v,meth} transaction word
// used by the ivector driver and its scoreboard.
package ivector_pkg;

  localparam int unsigned METH_W = 6;
  localparam int unsigned V_W    = 4;
  localparam int unsigned CNT_W  = 8;

  localparam logic [V_W-1:0] V_SEED = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [V_W-1:0]    v;
    logic [METH_W-1:0] meth;
  } txn_t;

  // Transaction i carries meth = i[5:0], v = i[3:0] ^ 4'hA.
  function automatic txn_t make_txn(input logic [CNT_W-1:0] idx);
    txn_t t;
    t.meth = idx[METH_W-1:0];
    t.v    = idx[V_W-1:0] ^ V_SEED;
    return t;
  endfunction

endpackage

// File: rtl/ivector_sb_fifo.sv
// In-order scoreboard of outstanding transactions: DEPTH-entry FIFO with
// full/empty flags and simultaneous enqueue/dequeue.
module ivector_sb_fifo
  import ivector_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_enq,
  input  txn_t i_data,
  input  logic i_deq,
  output txn_t o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  txn_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [OW-1:0] r_occ;
  logic          w_do_enq;
  logic          w_do_deq;

  assign o_full   = (r_occ == OW'(DEPTH));
  assign o_empty  = (r_occ == '0);
  assign o_data   = r_mem[r_rd_ptr];
  assign w_do_deq = i_deq && !o_empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_do_enq = i_enq && (!o_full || w_do_deq);

  always_ff @(posedge i_clk) begin
    if (w_do_enq) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_do_enq) r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + AW'(1);
      if (w_do_deq) r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + AW'(1);
      case ({w_do_enq, w_do_deq})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: rtl/ivector_driver.sv
// Issues a numbered sequence of say transactions, checks in-order heard
// responses against a scoreboard, and reports the mismatch count on done.
module ivector_driver
  import ivector_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              start__ENA,
  input  logic [CNT_W-1:0]  start_count,
  output logic              start__RDY,
  output logic              say__ENA,
  output logic [METH_W-1:0] say_meth,
  output logic [V_W-1:0]    say_v,
  input  logic              say__RDY,
  input  logic              heard__ENA,
  input  logic [METH_W-1:0] heard_meth,
  input  logic [V_W-1:0]    heard_v,
  output logic              heard__RDY,
  output logic              done__ENA,
  output logic [CNT_W-1:0]  done_errors,
  input  logic              done__RDY
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_sent;
  logic [CNT_W-1:0] r_recv;
  logic [CNT_W-1:0] r_errors;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_mismatch;
  txn_t             w_head;
  txn_t             w_say_txn;
  txn_t             w_heard_txn;

  ivector_sb_fifo #(.DEPTH(DEPTH)) u_sb (
    .i_clk   (CLK),
    .i_rst_n (nRST),
    .i_enq   (w_push),
    .i_data  (w_say_txn),
    .i_deq   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_say_txn        = make_txn(r_sent);
  assign say_meth         = w_say_txn.meth;
  assign say_v            = w_say_txn.v;
  assign w_heard_txn.meth = heard_meth;
  assign w_heard_txn.v    = heard_v;
  assign w_mismatch       = (w_heard_txn != w_head);
  assign w_push           = say__ENA;
  assign done_errors      = r_errors;

  always_comb begin
    w_state_nxt = r_state;
    start__RDY  = 1'b0;
    say__ENA    = 1'b0;
    heard__RDY  = 1'b0;
    done__ENA   = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        start__RDY = 1'b1;
        if (start__ENA) w_state_nxt = (start_count == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        heard__RDY = !w_empty;
        w_pop      = heard__ENA && !w_empty;
        say__ENA   = (r_sent < r_count) && (!w_full || w_pop) && say__RDY;
        if (r_recv == r_count) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done__ENA = done__RDY;
        if (done__RDY) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_sent   <= '0;
      r_recv   <= '0;
      r_errors <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && start__ENA) begin
        r_count  <= start_count;
        r_sent   <= '0;
        r_recv   <= '0;
        r_errors <= '0;
      end else if (r_state == ST_RUN) begin
        if (w_push) r_sent <= r_sent + CNT_W'(1);
        if (w_pop) begin
          r_recv <= r_recv + CNT_W'(1);
          if (w_mismatch && r_errors != '1) r_errors <= r_errors + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ivector_driver.sv
// Directed and randomized runs of ivector_driver against an in-bench model of
// transaction numbering, in-order echo responses and mismatch counting.
module tb_ivector_driver;

  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       start__ENA;
  logic [7:0] start_count;
  logic       start__RDY;
  logic       say__ENA;
  logic [5:0] say_meth;
  logic [3:0] say_v;
  logic       say__RDY;
  logic       heard__ENA;
  logic [5:0] heard_meth;
  logic [3:0] heard_v;
  logic       heard__RDY;
  logic       done__ENA;
  logic [7:0] done_errors;
  logic       done__RDY;

  int n_checks = 0;
  int n_errors = 0;

  ivector_driver #(.DEPTH(DEPTH)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .start__ENA  (start__ENA),
    .start_count (start_count),
    .start__RDY  (start__RDY),
    .say__ENA    (say__ENA),
    .say_meth    (say_meth),
    .say_v       (say_v),
    .say__RDY    (say__RDY),
    .heard__ENA  (heard__ENA),
    .heard_meth  (heard_meth),
    .heard_v     (heard_v),
    .heard__RDY  (heard__RDY),
    .done__ENA   (done__ENA),
    .done_errors (done_errors),
    .done__RDY   (done__RDY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start_rdy"}, 32'(start__RDY), 1);
    chk({tag, "_say_ena"}, 32'(say__ENA), 0);
    chk({tag, "_heard_rdy"}, 32'(heard__RDY), 0);
    chk({tag, "_done_ena"}, 32'(done__ENA), 0);
    chk({tag, "_done_err"}, 32'(done_errors), 0);
    chk({tag, "_meth"}, 32'(say_meth), 0);
    chk({tag, "_v"}, 32'(say_v), 32'hA);
  endtask

  // One run: start with cnt, echo says back (flipping v bit0 of response
  // flip_idx, or randomly in rnd mode), hold heard__ENA low for `hold`
  // cycles, keep done__RDY low for `ddly` cycles of DONE. With abort > 0 the
  // task returns at the negedge on which that many says have been seen.
  task automatic run(input int cnt, input int flip_idx, input bit rnd,
                     input int hold, input int ddly, input int abort);
    logic [9:0] q[$];
    logic [9:0] w;
    int  n_said = 0, n_recv = 0, exp_err = 0, cyc = 0;
    int  t_done;
    bit  hen, flip, got_done = 0;
    t_done = (cnt == 0) ? 0 : -1;

    @(posedge CLK); #1;
    start__ENA  = 1'b1;
    start_count = 8'(cnt);
    @(negedge CLK);
    chk("start_rdy_idle", 32'(start__RDY), 1);
    chk("no_say_in_idle", 32'(say__ENA), 0);
    @(posedge CLK); #1;
    start__ENA  = 1'b0;
    start_count = 8'($urandom);

    while (!got_done && cyc < 3000) begin
      say__RDY = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
      hen = (q.size() > 0) && (cyc >= hold) && (rnd ? ($urandom_range(0, 9) < 6) : 1'b1);
      flip = 1'b0;
      heard__ENA = hen;
      heard_meth = '0;
      heard_v    = '0;
      if (hen) begin
        w = q[0];
        flip = (n_recv == flip_idx) || (rnd && $urandom_range(0, 3) == 0);
        heard_meth = w[5:0];
        heard_v    = w[9:6] ^ {3'b000, flip};
      end
      done__RDY = (t_done < 0) ? 1'b1 : (cyc >= t_done + ddly);

      @(negedge CLK);
      if (t_done < 0 || cyc < t_done) begin
        chk("done_early", 32'(done__ENA), 0);
      end else if (cyc < t_done + ddly) begin
        chk("done_held", 32'(done__ENA), 0);
        chk("start_rdy_in_done", 32'(start__RDY), 0);
      end else begin
        chk("done_pulse", 32'(done__ENA), 1);
        chk("done_errors", 32'(done_errors), 32'(exp_err));
        got_done = 1;
      end

      if (n_said >= cnt) chk("say_overrun", 32'(say__ENA), 0);
      if (!say__RDY) chk("say_without_rdy", 32'(say__ENA), 0);
      if (n_said - n_recv == DEPTH && !hen) chk("say_when_full", 32'(say__ENA), 0);
      if (say__ENA && n_said < cnt) begin
        chk("say_meth", 32'(say_meth), 32'(n_said % 64));
        chk("say_v", 32'(say_v), 32'((n_said % 16) ^ 10));
        q.push_back({say_v, say_meth});
        n_said++;
      end
      if (hen) begin
        chk("heard_rdy", 32'(heard__RDY), 1);
        void'(q.pop_front());
        if (flip && exp_err < 255) exp_err++;
        n_recv++;
        if (n_recv == cnt) t_done = cyc + 2;
      end
      if (hold > 0 && cyc == hold - 1) chk("says_while_blocked", 32'(n_said), 32'(DEPTH));
      if (abort > 0 && n_said >= abort) begin
        heard__ENA = 1'b0;
        return;
      end
      cyc++;
      if (!got_done) begin
        @(posedge CLK); #1;
      end
    end

    heard__ENA = 1'b0;
    done__RDY  = 1'b1;
    chk("run_completed", 32'(got_done), 1);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("back_to_idle", 32'(start__RDY), 1);
    chk("done_single_pulse", 32'(done__ENA), 0);
  endtask

  initial begin
    nRST        = 1'b0;
    start__ENA  = 1'b0;
    start_count = '0;
    say__RDY    = 1'b1;
    heard__ENA  = 1'b0;
    heard_meth  = '0;
    heard_v     = '0;
    done__RDY   = 1'b1;

    #3;
    chk_reset_outputs("in_reset");
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    chk_reset_outputs("after_reset");

    run(3, -1, 0, 0, 0, 0);
    run(0, -1, 0, 0, 0, 0);
    run(10, -1, 0, 20, 0, 0);
    run(4, 1, 0, 0, 0, 0);

    run(8, -1, 0, 0, 0, 2);
    done__RDY = 1'b1;
    say__RDY  = 1'b1;
    #2;
    nRST = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    @(negedge CLK);
    nRST = 1'b1;
    run(1, -1, 0, 0, 0, 0);

    run(5, -1, 0, 0, 5, 0);

    for (int r = 0; r < 6; r++) begin
      run($urandom_range(1, 20), -1, 1, 0, $urandom_range(0, 3), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ivector_driver.md
IVECTOR_DRIVER -- requirements
Module: ivector_driver

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the maximum number of outstanding say transactions (scoreboard entries).
REQ-002 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 start__ENA  input  1  run request; start$count  input  8  transaction count; start__RDY  output  1  ready to accept start.
REQ-005 say__ENA  output  1  issue transaction; say$meth  output  6  method field; say$v  output  4  value field; say__RDY  input  1  target can accept.
REQ-006 heard__ENA  input  1  response valid; heard$meth  input  6; heard$v  input  4; heard__RDY  output  1  driver can accept response.
REQ-007 done__ENA  output  1  run-complete pulse; done$errors  output  8  mismatch count; done__RDY  input  1  sink can accept.

Function
REQ-008 The block SHALL implement states IDLE, RUN and DONE.
REQ-009 IDLE: start__RDY=1; when start__ENA=1, latch count and go to RUN, or go to DONE if count=0; clear sent, received and errors.
REQ-010 RUN and DONE: start__RDY=0; start__ENA SHALL be ignored.
REQ-011 Transaction i (0-based) SHALL carry meth = i[5:0] and v = i[3:0] XOR 4'hA.
REQ-012 say__ENA = RUN && sent<count && scoreboard not full && say__RDY, combinational on say__RDY; first say no earlier than the cycle after start is accepted.
REQ-013 On say__ENA the {v,meth} word SHALL be pushed into the scoreboard and sent incremented.
REQ-014 heard__RDY = RUN && scoreboard not empty; a response is accepted only when heard__ENA && heard__RDY.
REQ-015 On acceptance, heard$meth/heard$v SHALL be compared with the scoreboard head; the head is popped and received incremented.
REQ-016 On mismatch, errors SHALL increment, saturating at 255.
REQ-017 Push and pop in the same cycle SHALL both occur; occupancy is unchanged, and a full scoreboard may push when it pops that cycle.
REQ-018 RUN SHALL go to DONE on the cycle after received reaches count.
REQ-019 DONE: done__ENA = done__RDY; done$errors = errors; on done__ENA go to IDLE; with done__RDY low, remain in DONE indefinitely.
REQ-020 Response order SHALL be in-order FIFO; there is no timeout.
REQ-021 Counters SHALL be 8 bits; sent and received SHALL never exceed count.

Reset
REQ-022 nRST low SHALL immediately force IDLE and clear sent, received, errors, count and scoreboard pointers/occupancy, including mid-run.
REQ-023 During and after reset: start__RDY=1, say__ENA=0, heard__RDY=0, done__ENA=0, done$errors=0, say$meth=0, say$v=4'hA.

Structure
REQ-024 Package ivector_pkg SHALL hold METH_W=6, V_W=4, CNT_W=8, the state enum, and the packed {v,meth} transaction type.
REQ-025 The scoreboard SHALL be one sub-module, ivector_sb_fifo: DEPTH x 10-bit, with full/empty flags and simultaneous enq/deq.

Verification
REQ-026 count=3, echo responder with 1-cycle delay -> says (0,A),(1,B),(2,8); done__ENA once with errors=0; back in IDLE.
REQ-027 count=0 -> no say__ENA; done__ENA within 2 cycles with errors=0.
REQ-028 count=10, heard__ENA held low -> exactly 4 says, then say__ENA stays 0 until the first response.
REQ-029 count=4, responder flips v bit0 of transaction 1 -> errors=1 at done.
REQ-030 nRST pulsed low after 2 says of count=8 -> outputs reach reset values asynchronously; start__RDY=1; a new start with count=1 completes with errors=0.
REQ-031 done__RDY low for 5 cycles at end of run -> done__ENA=0 and start__RDY=0 throughout; done__ENA pulses on the first cycle done__RDY=1.
